// File: rtl/mode4_addertree_feeder.sv
// Mode-4 adder-tree feeder: packs a serial element stream into 4-lane groups, padding short tails with +0.0.
// Optional macro FEEDER_GROUP_CNT_EN adds a per-vector group counter output (group_cnt).
module mode4_addertree_feeder #(
    parameter int                   DATAWIDTH = 16,
    parameter int                   LANES     = 4,
    parameter logic [DATAWIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] outp0,
    output logic [DATAWIDTH-1:0] outp1,
    output logic [DATAWIDTH-1:0] outp2,
    output logic [DATAWIDTH-1:0] outp3,
    output logic                 out_last,
    output logic [2:0]           out_count
`ifdef FEEDER_GROUP_CNT_EN
    ,
    output logic [15:0]          group_cnt
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [DATAWIDTH-1:0] lane_q [LANES];
    logic [DATAWIDTH-1:0] lane_d [LANES];
    logic                 last_q, last_d;
    logic [2:0]           count_q, count_d;

    // Lanes beyond the accepted element are padded on the same edge that closes the group.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    lane_d[idx_q] = in_data;
                    if (idx_q == 2'(LANES - 1) || in_last) begin
                        state_d = HOLD;
                        for (int i = 0; i < LANES; i++) begin
                            if (i > int'(idx_q)) begin
                                lane_d[i] = PAD_VALUE;
                            end
                        end
                        count_d = {1'b0, idx_q} + 3'd1;
                        last_d  = in_last;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                    for (int i = 0; i < LANES; i++) begin
                        lane_d[i] = PAD_VALUE;
                    end
                    last_d  = 1'b0;
                    count_d = 3'd0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= FILL;
            idx_q   <= '0;
            last_q  <= 1'b0;
            count_q <= 3'd0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= PAD_VALUE;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            count_q <= count_d;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

`ifdef FEEDER_GROUP_CNT_EN
    logic [15:0] grpcnt_q, grpcnt_d;

    // Restarts on the final group of a vector so the count is per vector.
    always_comb begin
        grpcnt_d = grpcnt_q;
        if (state_q == HOLD && out_ready) begin
            grpcnt_d = last_q ? 16'd0 : grpcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            grpcnt_q <= 16'd0;
        end else begin
            grpcnt_q <= grpcnt_d;
        end
    end

    assign group_cnt = grpcnt_q;
`endif

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign outp0     = lane_q[0];
    assign outp1     = lane_q[1];
    assign outp2     = lane_q[2];
    assign outp3     = lane_q[3];
    assign out_last  = last_q;
    assign out_count = count_q;

endmodule

// File: doc/mode4_addertree_feeder.md
Name: mode4_adderTree_feeder

Overview:
- Transmit-side packer for the mode-4 floating-point adder tree.
- Accepts a serial stream of `DATAWIDTH` floating-point elements over a valid/ready handshake and groups them into 4-lane words (`outp0`..`outp3`).
- Presents each 4-lane word to the tree inputs with its own valid/ready handshake.
- Pads short final groups with +0.0 so the reduction result is unchanged.

Parameters:
- DATAWIDTH, `DATAWIDTH (16): element width, from defines.v.
- LANES, 4, fixed lane count; any other value is unsupported.
- PAD_VALUE, 0 (all bits zero), encoding of +0.0 written into unused lanes.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- resetn  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  upstream element valid.
- in_data  in  DATAWIDTH  upstream element.
- in_last  in  1  marks the final element of a vector.
- in_ready  out  1  feeder can accept an element.
- out_valid  out  1  4-lane group valid.
- out_ready  in  1  adder tree accepts the group.
- outp0..outp3  out  DATAWIDTH each  lane data; lane 0 is the earliest element.
- out_last  out  1  group contains the final element of a vector.
- out_count  out  3  number of real (non-pad) lanes, 1..4.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=FILL, lane index idx=0.
  - outp0..3 = PAD_VALUE.
  - out_valid=0, out_last=0, out_count=0.
  - in_ready is 1 the cycle after reset deasserts.
  - Reset mid-group discards any partially filled lanes, and reset overrides a simultaneous handshake.
- FSM has two states, FILL and HOLD.
- FILL:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, in_data is written to lane[idx] and idx increments.
  - If idx==3 or in_last=1 on the accepted element:
    - next state is HOLD;
    - lanes idx+1..3 are set to PAD_VALUE in the same edge;
    - out_count=idx+1;
    - out_last=in_last;
    - idx returns to 0.
- HOLD:
  - in_ready=0 and out_valid=1.
  - outp*, out_last and out_count stay stable until handshake.
  - On out_valid&&out_ready, next state is FILL, all lanes clear to PAD_VALUE, out_last=0 and out_count=0.
  - A stalled group (out_ready=0) is held indefinitely with no data change.
- Latency: out_valid rises 1 cycle after the edge that accepts the 4th or last element.
- Throughput: 4 accept cycles + at least 1 hold cycle per group; input is blocked while HOLD is occupied.
- in_last on the first element gives out_count=1 with lanes 1..3 padded.
- in_last on the 4th element gives out_count=4 with no pad.
- in_valid=0 in FILL: no state change and idx is held, so arbitrary bubbles between elements are allowed.
- Consecutive vectors need no gap: the first element of the next vector is accepted in the first FILL cycle after handshake.
- No arithmetic is performed; data bits pass through untouched (NaN/denormal payloads preserved).
- All outputs are registered; no combinational path from in_* to out_*.
- in_ready depends only on state.

Optional Feature:
- Macro: FEEDER_GROUP_CNT_EN.
- When defined:
  - adds output group_cnt[15:0], reset to 0;
  - increments on each out_valid&&out_ready handshake;
  - on a handshake with out_last=1 it loads 0 instead, giving a per-vector group count visible until the vector's final handshake;
  - wraps from 16'hFFFF to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Full group: after reset, send 3C00, 4000, 4200, 4400 (1.0, 2.0, 3.0, 4.0) back-to-back with in_last on the 4th, out_ready=1 -> one cycle later out_valid=1, outp0..3=3C00/4000/4200/4400, out_count=4, out_last=1; in_ready=0 for exactly 1 cycle.
- Short tail: send 3C00, 4000 with in_last on the 2nd -> outp0=3C00, outp1=4000, outp2=outp3=0000, out_count=2, out_last=1.
- Backpressure: complete a group with out_ready=0 for 5 cycles -> out_valid stays 1, outputs stable, in_ready=0 throughout; set out_ready=1 -> handshake, in_ready=1 next cycle.
- Bubbles plus multi-group vector: 6 elements 3C00 with random in_valid gaps, in_last on the 6th -> group1 count=4, last=0; group2 = 3C00,3C00,0000,0000 with count=2, last=1.
- Reset mid-fill: accept 2 elements, pull resetn low for 1 cycle -> outputs all 0, out_valid=0; the next 4 elements form a clean group with no stale data.
- FEEDER_GROUP_CNT_EN: 9-element vector -> group_cnt reads 1, then 2 after successive handshakes, then 0 after the last (count=1) group.
